// File: rtl/control_barras_pkg.sv
// control_barras_pkg
//   Shared definitions for the paddle-game sequencing controller:
//   FSM state encodings, winner codes and the score width.
package control_barras_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_P1   = 2'b01,
        W_P2   = 2'b10
    } winner_t;

    // Paddles may only move while a rally is being set up or played.
    function automatic logic move_allowed(input state_t s);
        return (s == ST_SERVE) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/control_barras_sincronizador.sv
// sincronizador
//   Two-flop synchronizer for a raw asynchronous button, with an optional
//   rising-edge pulse derived from the synchronized level.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   d      raw asynchronous input
//   q      synchronized level (2 cycles of latency)
//   rise   1-cycle pulse on a 0->1 transition of q (0 when EDGE_OUT=0)
module sincronizador #(
    parameter bit EDGE_OUT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

    generate
        if (EDGE_OUT) begin : g_edge
            logic q_prev;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_prev <= 1'b0;
                end else begin
                    q_prev <= q;
                end
            end

            assign rise = q & ~q_prev;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/control_barras.sv
// control_barras
//   Game-sequencing controller for the two-paddle game. Synchronizes the
//   player buttons, turns them into rate-limited one-cycle paddle step
//   commands, and runs the round FSM (idle, serve, play, point, over) that
//   keeps the scores and gates the ball module.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   btn_up1/down1/up2/down2, start  raw asynchronous buttons
//   miss_l, miss_r                  1-cycle pulses from the ball module
//   up1/down1/up2/down2             registered 1-cycle paddle step commands
//   bar_clr                         1-cycle pulse re-centring the paddles
//   ball_en                         ball module runs while high
//   score1, score2                  player scores (saturate at WIN_SCORE)
//   winner                          00 none, 01 player 1, 10 player 2
//   state                           current FSM state (debug)
module control_barras
    import control_barras_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int SERVE_TICKS = 50,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up1,
    input  logic               btn_down1,
    input  logic               btn_up2,
    input  logic               btn_down2,
    input  logic               start,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               up1,
    output logic               down1,
    output logic               up2,
    output logic               down2,
    output logic               bar_clr,
    output logic               ball_en,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SERVE_TICKS + 1);
    localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    // ---------------------------------------------------------------
    // Button synchronization
    // ---------------------------------------------------------------
    logic [3:0] btn_raw;
    logic [3:0] btn_sync;
    logic [3:0] btn_rise_unused;
    logic       start_sync;
    logic       start_rise;

    assign btn_raw = {btn_down2, btn_up2, btn_down1, btn_up1};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn_sync
            sincronizador #(.EDGE_OUT(1'b0)) u_sync (
                .clk  (clk),
                .reset(reset),
                .d    (btn_raw[i]),
                .q    (btn_sync[i]),
                .rise (btn_rise_unused[i])
            );
        end
    endgenerate

    sincronizador #(.EDGE_OUT(1'b1)) u_sync_start (
        .clk  (clk),
        .reset(reset),
        .d    (start),
        .q    (start_sync),
        .rise (start_rise)
    );

    logic up1_s, down1_s, up2_s, down2_s;
    assign {down2_s, up2_s, down1_s, up1_s} = btn_sync;

    // ---------------------------------------------------------------
    // Free-running paddle-step tick
    // ---------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Round FSM
    // ---------------------------------------------------------------
    state_t             state_q, state_d;
    winner_t            winner_q, winner_d;
    logic [SW-1:0]      serve_cnt, serve_d;
    logic [SCORE_W-1:0] score1_d, score2_d;
    logic               bar_clr_d;

    assign state  = state_q;
    assign winner = winner_q;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        serve_d   = serve_cnt;
        score1_d  = score1;
        score2_d  = score2;
        bar_clr_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d   = ST_SERVE;
                    score1_d  = '0;
                    score2_d  = '0;
                    winner_d  = W_NONE;
                    serve_d   = '0;
                    bar_clr_d = 1'b1;
                end
            end

            ST_SERVE: begin
                if (tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        serve_d = '0;
                    end else begin
                        serve_d = serve_cnt + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                // A simultaneous miss on both edges ends the rally without
                // awarding a point to either side.
                if (miss_l || miss_r) begin
                    state_d = ST_POINT;
                end
                if (miss_r && !miss_l && (score1 < WIN)) begin
                    score1_d = score1 + 1'b1;
                end
                if (miss_l && !miss_r && (score2 < WIN)) begin
                    score2_d = score2 + 1'b1;
                end
            end

            ST_POINT: begin
                if (score1 == WIN) begin
                    state_d  = ST_OVER;
                    winner_d = W_P1;
                end else if (score2 == WIN) begin
                    state_d  = ST_OVER;
                    winner_d = W_P2;
                end else begin
                    state_d   = ST_SERVE;
                    serve_d   = '0;
                    bar_clr_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            winner_q  <= W_NONE;
            serve_cnt <= '0;
            score1    <= '0;
            score2    <= '0;
            bar_clr   <= 1'b0;
            ball_en   <= 1'b0;
            up1       <= 1'b0;
            down1     <= 1'b0;
            up2       <= 1'b0;
            down2     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            serve_cnt <= serve_d;
            score1    <= score1_d;
            score2    <= score2_d;
            bar_clr   <= bar_clr_d;
            // Registered from the next state so the ball starts on the
            // very first PLAY cycle.
            ball_en   <= (state_d == ST_PLAY);
            // Step commands use the current state: paddles freeze as soon
            // as the FSM leaves SERVE/PLAY.
            up1       <= tick & move_allowed(state_q) & up1_s   & ~down1_s;
            down1     <= tick & move_allowed(state_q) & down1_s & ~up1_s;
            up2       <= tick & move_allowed(state_q) & up2_s   & ~down2_s;
            down2     <= tick & move_allowed(state_q) & down2_s & ~up2_s;
        end
    end

endmodule

// File: tb/tb_control_barras.sv
// tb_control_barras
//   Self-checking bench for control_barras with small parameters. A
//   behavioural reference model tracks input history, tick timing and the
//   game rules; every cycle all outputs are compared against it, on top of
//   directed scenario checks and a randomized phase.
module tb_control_barras;

    localparam int TD  = 4;   // TICK_DIV
    localparam int STK = 3;   // SERVE_TICKS
    localparam int WS  = 2;   // WIN_SCORE

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up1 = 1'b0, btn_down1 = 1'b0, btn_up2 = 1'b0, btn_down2 = 1'b0;
    logic       start = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic       up1, down1, up2, down2, bar_clr, ball_en;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state;

    control_barras #(
        .TICK_DIV   (TD),
        .SERVE_TICKS(STK),
        .WIN_SCORE  (WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up1  (btn_up1),
        .btn_down1(btn_down1),
        .btn_up2  (btn_up2),
        .btn_down2(btn_down2),
        .start    (start),
        .miss_l   (miss_l),
        .miss_r   (miss_r),
        .up1      (up1),
        .down1    (down1),
        .up2      (up2),
        .down2    (down2),
        .bar_clr  (bar_clr),
        .ball_en  (ball_en),
        .score1   (score1),
        .score2   (score2),
        .winner   (winner),
        .state    (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 serve, 2 play, 3 point, 4 over.
    int       edge_no;
    int       m_state, m_s1, m_s2, m_win, m_ticks_served;
    bit       m_clr, m_ball;
    bit [3:0] m_cmd;           // {up1, down1, up2, down2}
    bit [4:0] hist[$];         // raw inputs seen at each edge: {start,d2,u2,d1,u1}
    int       n_up1, n_down1, n_any_cmd, n_clr;

    function automatic bit [4:0] seen(input int ago);
        if (hist.size() > ago) return hist[hist.size() - 1 - ago];
        return 5'b0;
    endfunction

    task automatic model_reset();
        edge_no        = 0;
        m_state        = 0;
        m_s1           = 0;
        m_s2           = 0;
        m_win          = 0;
        m_ticks_served = 0;
        m_clr          = 1'b0;
        m_ball         = 1'b0;
        m_cmd          = 4'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        bit [4:0] b2, b3;
        bit       tick, rise, movable;
        hist.push_back({start, btn_down2, btn_up2, btn_down1, btn_up1});
        edge_no++;
        b2      = seen(2);   // buttons as seen through two synchronizer flops
        b3      = seen(3);
        tick    = (edge_no % TD) == 0;
        rise    = b2[4] && !b3[4];
        movable = (m_state == 1) || (m_state == 2);
        m_cmd   = {tick && movable && b2[0] && !b2[1],
                   tick && movable && b2[1] && !b2[0],
                   tick && movable && b2[2] && !b2[3],
                   tick && movable && b2[3] && !b2[2]};
        m_clr   = 1'b0;
        case (m_state)
            0, 4: if (rise) begin
                m_state = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
                m_ticks_served = 0; m_clr = 1'b1;
            end
            1: if (tick) begin
                m_ticks_served++;
                if (m_ticks_served == STK) m_state = 2;
            end
            2: begin
                if (miss_l && miss_r) m_state = 3;
                else if (miss_r) begin m_s1 = (m_s1 < WS) ? m_s1 + 1 : WS; m_state = 3; end
                else if (miss_l) begin m_s2 = (m_s2 < WS) ? m_s2 + 1 : WS; m_state = 3; end
            end
            3: begin
                if (m_s1 == WS)      begin m_state = 4; m_win = 1; end
                else if (m_s2 == WS) begin m_state = 4; m_win = 2; end
                else begin m_state = 1; m_ticks_served = 0; m_clr = 1'b1; end
            end
            default: m_state = 0;
        endcase
        m_ball = (m_state == 2);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("state",   8'(state),   8'(m_state));
        check("score1",  8'(score1),  8'(m_s1));
        check("score2",  8'(score2),  8'(m_s2));
        check("winner",  8'(winner),  8'(m_win));
        check("ball_en", 8'(ball_en), 8'(m_ball));
        check("bar_clr", 8'(bar_clr), 8'(m_clr));
        check("cmds",    8'({up1, down1, up2, down2}), 8'(m_cmd));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (up1)   n_up1++;
        if (down1) n_down1++;
        if (up1 || down1 || up2 || down2) n_any_cmd++;
        if (bar_clr) n_clr++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int i;
        i = 0;
        while (m_state != s && i < budget) begin
            cycle();
            i++;
        end
        check(tag, 8'(state), 8'(s));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        run(3);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("reset_state", 8'(state), 8'd0);

        // Idle buttons: no step pulses at all.
        n_any_cmd = 0;
        run(40);
        check("idle_no_steps", 8'(n_any_cmd), 8'd0);

        // Start: one bar_clr pulse, serve, then play with ball enabled.
        n_clr = 0;
        pulse_start();
        wait_state(2, 30, "reach_play");
        check("start_clr_pulses", 8'(n_clr), 8'd1);
        check("play_ball_en", 8'(ball_en), 8'd1);
        check("play_scores", 8'({score1, score2}), 8'd0);

        // Up held 20 cycles -> exactly 5 step pulses, never down.
        n_up1 = 0; n_down1 = 0;
        btn_up1 = 1'b1;
        run(20);
        btn_up1 = 1'b0;
        run(4);
        check("up1_pulses", 8'(n_up1), 8'd5);
        check("down1_pulses", 8'(n_down1), 8'd0);

        // Both buttons held -> no steps.
        n_up1 = 0; n_down1 = 0;
        btn_up1 = 1'b1; btn_down1 = 1'b1;
        run(20);
        btn_up1 = 1'b0; btn_down1 = 1'b0;
        run(4);
        check("both_pulses", 8'(n_up1 + n_down1), 8'd0);

        // First point for player 1.
        miss_r = 1'b1;
        cycle();
        miss_r = 1'b0;
        check("pt1_score1", 8'(score1), 8'd1);
        check("pt1_point", 8'(state), 8'd3);
        check("pt1_ball_off", 8'(ball_en), 8'd0);
        cycle();
        check("pt1_serve", 8'(state), 8'd1);
        check("pt1_clr", 8'(bar_clr), 8'd1);
        wait_state(2, 30, "replay");

        // Second point wins the game.
        miss_r = 1'b1;
        cycle();
        miss_r = 1'b0;
        cycle();
        check("win_state", 8'(state), 8'd4);
        check("win_winner", 8'(winner), 8'd1);
        check("win_score1", 8'(score1), 8'd2);
        run(10);
        check("over_held", 8'(state), 8'd4);

        // Restart from OVER clears everything.
        pulse_start();
        wait_state(1, 10, "restart_serve");
        check("restart_clr", 8'(bar_clr), 8'd1);
        check("restart_scores", 8'({score1, score2}), 8'd0);
        check("restart_winner", 8'(winner), 8'd0);
        wait_state(2, 30, "restart_play");

        // Simultaneous misses: no score, point then serve.
        miss_l = 1'b1; miss_r = 1'b1;
        cycle();
        miss_l = 1'b0; miss_r = 1'b0;
        check("dbl_point", 8'(state), 8'd3);
        check("dbl_scores", 8'({score1, score2}), 8'd0);
        cycle();
        check("dbl_serve", 8'(state), 8'd1);

        // Miss during SERVE is ignored.
        miss_l = 1'b1;
        cycle();
        miss_l = 1'b0;
        check("serve_miss_score2", 8'(score2), 8'd0);
        check("serve_miss_state", 8'(state), 8'd1);

        // Randomized play against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_up1   = ~btn_up1;
            if ($urandom_range(0, 5) == 0) btn_down1 = ~btn_down1;
            if ($urandom_range(0, 5) == 0) btn_up2   = ~btn_up2;
            if ($urandom_range(0, 5) == 0) btn_down2 = ~btn_down2;
            start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) {miss_l, miss_r} = 2'($urandom_range(1, 3));
            else {miss_l, miss_r} = 2'b00;
            cycle();
        end
        {btn_up1, btn_down1, btn_up2, btn_down2, start, miss_l, miss_r} = 7'b0;
        run(4);

        // Reset asserted mid-play takes effect without a clock edge.
        if (m_state == 0 || m_state == 4) pulse_start();
        wait_state(2, 60, "final_play");
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("async_reset_state", 8'(state), 8'd0);
        check("async_reset_clr", 8'(bar_clr), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_barras.md
Name: control_barras

Overview:
- Game-sequencing controller for the two-paddle game.
- Turns raw player buttons into rate-limited one-cycle up/down step commands for the two barra paddle instances.
- Runs the round state machine: idle, serve, play, point, game over. Keeps per-player scores and gates the ball module.
- Sits between the board I/O (buttons, start) and the barra/ball datapath; all in one clock domain.

Parameters:
- TICK_DIV, 100000: clocks per paddle-step tick (>=2).
- SERVE_TICKS, 50: ticks spent in SERVE before the ball is released (>=1).
- WIN_SCORE, 9: score that ends the game (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_up1, btn_down1, btn_up2, btn_down2  in  1 each  raw asynchronous player buttons.
- start  in  1  raw asynchronous start button.
- miss_l  in  1  sync 1-cycle pulse from ball module: ball passed left edge (player 2 scores).
- miss_r  in  1  sync 1-cycle pulse: ball passed right edge (player 1 scores).
- up1, down1, up2, down2  out  1 each  registered 1-cycle step commands to the barra instances.
- bar_clr  out  1  active-high 1-cycle pulse to barra reset inputs (re-centres paddles).
- ball_en  out  1  level; ball module runs while high.
- score1, score2  out  4 each  player scores.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (reset=0, async): state=IDLE, tick counter=0, synchronizers cleared, all outputs 0.
- Synchronization:
  - Every button passes a 2-flop synchronizer.
  - start additionally gets a rising-edge detector (start_rise).
  - Button-to-command latency is 2 sync cycles + tick wait + 1 register cycle.
- Tick generation:
  - Free-running counter 0..TICK_DIV-1, running in every state.
  - tick=1 on the cycle the count is TICK_DIV-1, then the counter wraps to 0.
- Paddle commands (per player n), registered one cycle after the tick cycle:
  - upn = tick & move_ok & up_sync & ~down_sync.
  - downn is symmetric.
  - Both buttons held -> no step. Never upn and downn together.
  - move_ok = state in {SERVE, PLAY}. Paddles are frozen in IDLE, POINT, OVER.
- FSM states: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
  - IDLE: ball_en=0. On start_rise -> SERVE. Same edge: score1=score2=0, winner=00, bar_clr=1 for one cycle, serve counter=0.
  - SERVE: ball_en=0. Serve counter increments on each tick. When it reaches SERVE_TICKS -> PLAY.
  - PLAY: ball_en=1 (registered, asserted the first PLAY cycle).
    - miss_r alone -> score1+1, go POINT.
    - miss_l alone -> score2+1, go POINT.
    - miss_l and miss_r in the same cycle -> no score change, go POINT.
    - start_rise ignored.
  - POINT (exactly 1 cycle): ball_en=0.
    - If score1==WIN_SCORE -> OVER with winner=01.
    - Else if score2==WIN_SCORE -> OVER with winner=10.
    - Else -> SERVE with bar_clr=1 for one cycle and serve counter=0.
  - OVER: ball_en=0; scores and winner held. start_rise -> same actions as IDLE's start.
- miss_l/miss_r outside PLAY are ignored.
- Scores saturate at WIN_SCORE; no wrap.
- Undefined state encodings -> IDLE.
- Reset asserted mid-game: immediate return to reset values; no bar_clr pulse is generated (barra is reset separately).

Decomposition:
- Package control_barras_pkg holds:
  - state encodings ST_IDLE..ST_OVER.
  - winner codes W_NONE, W_P1, W_P2.
  - score width SCORE_W=4.
- One sub-module, sincronizador: 2-flop synchronizer with optional rising-edge output. Instantiated 5 times.

Test Plan (TICK_DIV=4, SERVE_TICKS=3, WIN_SCORE=2):
- Reset held low for 3 cycles, then released -> state=0, all outputs 0; no step pulses with buttons idle for 40 cycles.
- start pulse -> bar_clr high exactly 1 cycle, state=1; ball_en rises after 3 ticks (~12 cycles); scores 0.
- In PLAY, btn_up1 held for 20 cycles -> up1 1-cycle pulses every 4 cycles (5 pulses), down1=0. Then btn_up1+btn_down1 held -> no pulses.
- In PLAY, miss_r pulse -> score1=1, ball_en drops, 1 POINT cycle, bar_clr pulse, back to SERVE. A second miss_r after replay -> score1=2, state=4, winner=01, ball_en=0.
- In PLAY, miss_l and miss_r in the same cycle -> scores unchanged, POINT then SERVE. miss_l pulsed during SERVE -> ignored.
- In OVER, start pulse -> scores cleared, winner=00, bar_clr pulse, SERVE. Then reset asserted while in PLAY -> outputs 0, state=0 asynchronously.
